// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU ops,
// instruction-class opcodes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } statetype_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Only the adder/subtractor produce meaningful C and V flags.
  function automatic logic is_arith(input logic [1:0] ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decoder: maps Funct to ALU operation and flag/writeback
// qualifiers while the FSM is in an execute state.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic       alu_op,
  input  logic [5:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write
);

  logic known;

  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    no_write    = 1'b0;
    known       = 1'b1;
    if (alu_op) begin
      unique case (funct[4:1])
        4'b0100: alu_control = ALU_ADD;
        4'b0010: alu_control = ALU_SUB;
        4'b0000: alu_control = ALU_AND;
        4'b1100: alu_control = ALU_ORR;
        4'b1010: begin
          alu_control = ALU_SUB;
          no_write    = 1'b1;
        end
        default: begin
          // Unsupported opcode: harmless ADD with all architectural writes blocked.
          alu_control = ALU_ADD;
          no_write    = 1'b1;
          known       = 1'b0;
        end
      endcase
      if (known) begin
        flag_w[1] = funct[0];
        flag_w[0] = funct[0] & is_arith(alu_control);
      end
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Instruction-side control FSM for the multicycle ARM datapath: state register,
// next-state logic and per-state datapath select decode.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter statetype_t RESET_STATE = FETCH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NoWrite,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  statetype_t state, next_state;
  logic       alu_op;
  logic       branch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RESET_STATE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    unique case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        unique case (Op)
          OP_MEM:  next_state = MEMADR;
          OP_DP:   next_state = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   next_state = BRANCH;
          default: next_state = FETCH;   // undefined class: retire with no writes
        endcase
      end
      MEMADR:   next_state = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = FETCH;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BRANCH:   next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_RN;
    ALUSrcB   = SRCB_RM;
    RegW      = 1'b0;
    MemW      = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    unique case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      MEMADR:   ALUSrcB = SRCB_IMM;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        alu_op  = 1'b1;
      end
      ALUWB:    RegW = 1'b1;
      BRANCH: begin
        ALUSrcA   = SRCA_ALUOUT;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct       (Funct),
    .alu_control (ALUControl),
    .flag_w      (FlagW),
    .no_write    (NoWrite)
  );

  assign PCS    = branch | (RegW & (Rd == 4'hF));
  assign ImmSrc = Op;
  assign RegSrc = {Op == OP_MEM, Op == OP_BR};

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed instruction table, reset-abort sequence and
// random instructions against an instruction-level reference model.
module tb_multicycle_control_unit;

  logic       clk, rst;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, RegW, MemW, NoWrite, IRWrite, NextPC, AdrSrc;
  logic [1:0] FlagW, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .FlagW(FlagW),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {PF, PD, PMA, PMR, PMWB, PMST, PER, PEI, PAW, PB} ph_t;

  typedef struct packed {
    logic       pcs, regw, memw, nowrite;
    logic [1:0] flagw;
    logic       irwrite, nextpc, adrsrc;
    logic [1:0] res, srca, srcb, alu, immsrc, regsrc;
  } out_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    int         lat;
    int         regw_at;
    int         memw_at;
    logic       pcs;
    logic [4:0] ex;   // {ALUControl, FlagW, NoWrite} in the third cycle
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction length in cycles, from the instruction class alone.
  function automatic int ilen(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b01:   return f[0] ? 5 : 4;
      2'b00:   return 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic ph_t step(input logic [1:0] op, input logic [5:0] f, input int i);
    if (i == 0) return PF;
    if (i == 1) return PD;
    case (op)
      2'b01:   return (i == 2) ? PMA : (!f[0] ? PMST : (i == 3 ? PMR : PMWB));
      2'b00:   return (i == 2) ? (f[5] ? PEI : PER) : PAW;
      2'b10:   return PB;
      default: return PF;
    endcase
  endfunction

  function automatic out_t model(input ph_t p, input logic [1:0] op,
                                 input logic [5:0] f, input logic [3:0] rd);
    out_t o;
    o = '0;
    o.immsrc = op;
    o.regsrc = {op == 2'b01, op == 2'b10};
    case (p)
      PF:   begin o.irwrite = 1; o.nextpc = 1; o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10; end
      PD:   begin o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10; end
      PMA:  o.srcb = 2'b01;
      PMR:  o.adrsrc = 1;
      PMWB: begin o.res = 2'b01; o.regw = 1; end
      PMST: begin o.adrsrc = 1; o.memw = 1; end
      PER, PEI: begin
        o.srcb = (p == PEI) ? 2'b01 : 2'b00;
        case (f[4:1])
          4'd4:  begin o.alu = 2'b00; o.flagw = {f[0], f[0]}; end
          4'd2:  begin o.alu = 2'b01; o.flagw = {f[0], f[0]}; end
          4'd0:  begin o.alu = 2'b10; o.flagw = {f[0], 1'b0}; end
          4'd12: begin o.alu = 2'b11; o.flagw = {f[0], 1'b0}; end
          4'd10: begin o.alu = 2'b01; o.flagw = {f[0], f[0]}; o.nowrite = 1; end
          default: begin o.alu = 2'b00; o.flagw = 2'b00; o.nowrite = 1; end
        endcase
      end
      PAW:  o.regw = 1;
      PB:   begin o.srca = 2'b10; o.srcb = 2'b01; o.res = 2'b10; end
      default: ;
    endcase
    o.pcs = (p == PB) || (o.regw && rd == 4'hF);
    return o;
  endfunction

  function automatic out_t grab();
    out_t o;
    o.pcs = PCS; o.regw = RegW; o.memw = MemW; o.nowrite = NoWrite;
    o.flagw = FlagW; o.irwrite = IRWrite; o.nextpc = NextPC; o.adrsrc = AdrSrc;
    o.res = ResultSrc; o.srca = ALUSrcA; o.srcb = ALUSrcB; o.alu = ALUControl;
    o.immsrc = ImmSrc; o.regsrc = RegSrc;
    return o;
  endfunction

  // Entered #1 after the edge that put the FSM into FETCH; leaves at the same
  // point of the following FETCH.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                           output int lat, output int regw_at, output int memw_at,
                           output logic pcs_seen, output logic [4:0] ex);
    int n;
    Op = op; Funct = f; Rd = rd;
    n = ilen(op, f);
    lat = 99; regw_at = -1; memw_at = -1; pcs_seen = 1'b0; ex = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("step%0d op%0d f%02h", i, op, f), 32'(grab()), 32'(model(step(op, f, i), op, f, rd)));
      if (i > 0 && IRWrite && lat == 99) lat = i;
      if (RegW && regw_at < 0) regw_at = i;
      if (MemW && memw_at < 0) memw_at = i;
      pcs_seen = pcs_seen | PCS;
      if (i == 2) ex = {ALUControl, FlagW, NoWrite};
      @(posedge clk); #1;
    end
    if (lat == 99 && IRWrite) lat = n;
  endtask

  vec_t tbl[12];
  localparam logic [9:0] FETCH_SIG = {1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10};

  initial begin
    int lat, ra, ma;
    logic ps;
    logic [4:0] ex;

    tbl[0]  = '{2'b01, 6'b011001, 4'd3,  5,  4, -1, 1'b0, 5'b00_00_0}; // LDR
    tbl[1]  = '{2'b01, 6'b011000, 4'd3,  4, -1,  3, 1'b0, 5'b00_00_0}; // STR
    tbl[2]  = '{2'b00, 6'b101001, 4'd2,  4,  3, -1, 1'b0, 5'b00_11_0}; // ADDS imm
    tbl[3]  = '{2'b00, 6'b000100, 4'd1,  4,  3, -1, 1'b0, 5'b01_00_0}; // SUB reg
    tbl[4]  = '{2'b00, 6'b010101, 4'd0,  4,  3, -1, 1'b0, 5'b01_11_1}; // CMP
    tbl[5]  = '{2'b00, 6'b011001, 4'd4,  4,  3, -1, 1'b0, 5'b11_10_0}; // ORRS
    tbl[6]  = '{2'b00, 6'b000000, 4'd5,  4,  3, -1, 1'b0, 5'b10_00_0}; // AND
    tbl[7]  = '{2'b10, 6'b101000, 4'd0,  3, -1, -1, 1'b1, 5'b00_00_0}; // B
    tbl[8]  = '{2'b00, 6'b001000, 4'hF,  4,  3, -1, 1'b1, 5'b00_00_0}; // ADD pc
    tbl[9]  = '{2'b11, 6'b010101, 4'd7,  2, -1, -1, 1'b0, 5'b00_00_0}; // undefined
    tbl[10] = '{2'b00, 6'b100111, 4'd6,  4,  3, -1, 1'b0, 5'b00_00_1}; // unknown op
    tbl[11] = '{2'b01, 6'b000001, 4'hF,  5,  4, -1, 1'b1, 5'b00_00_0}; // LDR pc

    rst = 1'b0; Op = 2'b00; Funct = '0; Rd = '0;
    #2;
    chk("reset_fetch_decode", 32'({IRWrite, NextPC, RegW, MemW, ALUSrcA, ALUSrcB, ResultSrc}), 32'(FETCH_SIG));
    chk("reset_quiet", 32'({AdrSrc, PCS, NoWrite, FlagW, ALUControl}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (tbl[k]) begin
      run_instr(tbl[k].op, tbl[k].funct, tbl[k].rd, lat, ra, ma, ps, ex);
      chk($sformatf("v%0d latency", k), 32'(lat), 32'(tbl[k].lat));
      chk($sformatf("v%0d regw_cycle", k), 32'(ra), 32'(tbl[k].regw_at));
      chk($sformatf("v%0d memw_cycle", k), 32'(ma), 32'(tbl[k].memw_at));
      chk($sformatf("v%0d pcs", k), 32'(ps), 32'(tbl[k].pcs));
      if (tbl[k].lat > 2) chk($sformatf("v%0d exec_alu", k), 32'(ex), 32'(tbl[k].ex));
    end

    // Reset asserted during MEMREAD must abort the load before MEMWB.
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("memread_reached", 32'({AdrSrc, RegW, MemW}), 32'b100);
    #2 rst = 1'b0;
    #1;
    chk("abort_fetch", 32'({IRWrite, NextPC, RegW, MemW, ALUSrcA, ALUSrcB, ResultSrc}), 32'(FETCH_SIG));
    chk("abort_adrsrc", 32'(AdrSrc), 32'd0);
    @(posedge clk); #1;
    chk("abort_hold", 32'({IRWrite, NextPC, RegW, MemW, ALUSrcA, ALUSrcB, ResultSrc}), 32'(FETCH_SIG));
    rst = 1'b1;
    run_instr(2'b01, 6'b011000, 4'd2, lat, ra, ma, ps, ex);
    chk("post_abort_str_latency", 32'(lat), 32'd4);
    chk("post_abort_str_memw", 32'(ma), 32'd3);

    for (int r = 0; r < 60; r++) begin
      logic [1:0] rop;
      logic [5:0] rf;
      logic [3:0] rrd;
      rop = 2'($urandom_range(0, 3));
      rf  = 6'($urandom);
      rrd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      run_instr(rop, rf, rrd, lat, ra, ma, ps, ex);
      chk($sformatf("rand%0d latency", r), 32'(lat), 32'(ilen(rop, rf)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Instruction-side control FSM for the multicycle ARM datapath.
- Produces the PCS/RegW/MemW/NoWrite/FlagW qualifiers that the conditional-execution unit gates, plus all datapath mux and enable selects.
- Steps each instruction through Fetch, Decode and 1–3 execute states, sequencing fetch, memory, ALU and branch operations over multiple clocks.
- Sits between the instruction register and the conditional-execution unit.

Parameters:
- RESET_STATE, FETCH, state entered on reset (fixed; kept as a parameter only for bench visibility).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- PCS  out  1  PC-write-by-instruction qualifier
- RegW  out  1  register-write qualifier
- MemW  out  1  memory-write qualifier
- NoWrite  out  1  suppress register write (CMP)
- FlagW  out  2  flag-write qualifiers: [1]=N,Z; [0]=C,V
- IRWrite  out  1  instruction-register load
- NextPC  out  1  unconditional PC update (fetch)
- AdrSrc  out  1  0=PC, 1=ALU result
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALU direct
- ALUSrcA  out  2  00=Rn, 01=PC, 10=ALUOut
- ALUSrcB  out  2  00=Rm, 01=ExtImm, 10=const 4
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)

Behaviour:
- Clock and reset: one clock domain. rst low asynchronously forces state to FETCH. While in reset, outputs take the FETCH decode: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, AdrSrc=0, all other outputs 0.
- Default output value: any output not listed for a state is 0.
- State outputs:
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 -> EXECUTEI if Funct[5] else EXECUTER; Op=10 -> BRANCH; Op=11 -> FETCH (undefined instruction, no writes).
  - MEMADR: Funct[0]=1 (LDR) -> MEMREAD, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER or EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Instruction latencies: LDR 5 cycles; STR and data-processing 4 cycles; branch 3 cycles; undefined 2 cycles.
- PCS = Branch | (RegW & (Rd==4'hF)). PCS is combinational from state and Rd.
- ALU decode: active only when ALUOp=1, keyed on Funct[4:1]:
  - 0100 -> ADD
  - 0010 -> SUB
  - 0000 -> AND
  - 1100 -> ORR
  - 1010 (CMP) -> SUB with NoWrite=1
  - any other code -> ADD, NoWrite=1, FlagW=00
- Flag writes: when ALUOp=1, FlagW[1]=Funct[0] and FlagW[0]=Funct[0]&(ALUControl is ADD or SUB). When ALUOp=0: ALUControl=ADD, FlagW=00, NoWrite=0.
- Funct, Op and Rd are stable from DECODE through the last state, because IRWrite is high only in FETCH. Outputs are combinational from state and these fields, with no extra latency.
- Reset asserted mid-instruction aborts it: state returns to FETCH immediately and no further RegW or MemW pulses occur.

Decomposition:
- Shared package ctrl_pkg:
  - state enum statetype_t (10 states)
  - ALUControl encodings ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR
  - Op encodings OP_DP, OP_MEM, OP_BR
  - mux-select constants for SRCA_*, SRCB_*, RES_*
- Natural sub-module: alu_decoder (combinational). Inputs ALUOp and Funct; outputs ALUControl, FlagW, NoWrite.
- Top file holds the state register, next-state logic and output decode.

Test Plan:
- Reset: hold rst=0 mid-MEMREAD, then release -> state FETCH, IRWrite=1, NextPC=1, RegW=0, MemW=0 on the first edge after release.
- LDR: Op=01, Funct=011001, Rd=3 -> state trace FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegW=1 only in cycle 5; PCS=0.
- STR: Op=01, Funct=011000 -> trace FETCH,DECODE,MEMADR,MEMWRITE; MemW=1 only in cycle 4; RegW=0 throughout.
- ADDS immediate: Op=00, Funct=101001 -> EXECUTEI with ALUControl=00, FlagW=11; then ALUWB with RegW=1. SUB register Op=00, Funct=000100 -> EXECUTER with ALUControl=01, FlagW=00.
- CMP: Op=00, Funct=010101 -> ALUControl=01, NoWrite=1, FlagW=11. ORRS: Funct=011001 -> ALUControl=11, FlagW=10.
- Branch and PC-targeted writes: Op=10 -> BRANCH with PCS=1, ALUSrcA=10, ALUSrcB=01, then FETCH. ADD with Rd=15 -> PCS=1 in ALUWB. Op=11 -> DECODE then FETCH with no writes.
